// File: rtl/multicycle_subtractor_if.sv
// Operand/result handshake bundle for the iterative subtractor.
// The slave side is the subtractor and the master side is its user.
interface multicycle_subtractor_if #(
  parameter int WIDTH = 64
);
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_minuend;
  logic [WIDTH-1:0] i_subtrahend;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_result;
  logic             o_borrow;
  logic             o_overflow;

  modport slave (
    input  i_valid, i_minuend, i_subtrahend, i_ready,
    output o_ready, o_valid, o_result, o_borrow, o_overflow
  );

  modport master (
    output i_valid, i_minuend, i_subtrahend, i_ready,
    input  o_ready, o_valid, o_result, o_borrow, o_overflow
  );
endinterface

// File: rtl/multicycle_subtractor.sv
// Iterative A - B over WIDTH bits, CHUNK bits per clock, with a registered borrow
// between slices; flags unsigned borrow and signed overflow at completion.
module multicycle_subtractor #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  multicycle_subtractor_if.slave bus
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;
  logic [CHUNK:0]   sub;

  // Operands shift down each step, so the active slice is always the low chunk
  // and on the last step the low chunk carries the operand sign bits.
  assign sub = {1'b0, a_q[CHUNK-1:0]} - {1'b0, b_q[CHUNK-1:0]} - (CHUNK+1)'(brw_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    brw_d    = brw_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          a_d      = bus.i_minuend;
          b_d      = bus.i_subtrahend;
          cnt_d    = '0;
          brw_d    = 1'b0;
          res_d    = '0;
          borrow_d = 1'b0;
          ovf_d    = 1'b0;
          state_d  = CALC;
        end
      end
      CALC: begin
        for (int k = 0; k < NCH; k++) begin
          if (cnt_q == CW'(k)) res_d[k*CHUNK +: CHUNK] = sub[CHUNK-1:0];
        end
        a_d   = a_q >> CHUNK;
        b_d   = b_q >> CHUNK;
        brw_d = sub[CHUNK];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          borrow_d = sub[CHUNK];
          ovf_d    = (a_q[CHUNK-1] != b_q[CHUNK-1]) && (sub[CHUNK-1] != a_q[CHUNK-1]);
          cnt_d    = '0;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (bus.i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      brw_q    <= 1'b0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      brw_q    <= brw_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  // Operand registers carry no reset value; they are reloaded on every accept.
  always_ff @(posedge i_clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign bus.o_ready    = (state_q == IDLE);
  assign bus.o_valid    = (state_q == DONE);
  assign bus.o_result   = res_q;
  assign bus.o_borrow   = borrow_q;
  assign bus.o_overflow = ovf_q;
endmodule
